round: RTL and testbench

ROUND -- requirements
Module: round

---
 rtl/round_pkg.sv | 46 ++++
 rtl/round_aes_sbox.sv | 11 +
 rtl/round.sv | 74 +++++++
 tb/tb_round.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// Shared AES-128 round definitions: state array type, forward S-box table
// and the GF(2^8) multiply-by-02 helper.
package round_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/round_aes_sbox.sv
// Combinational AES forward S-box lookup, one byte.
module aes_sbox
    import round_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/round.sv
// One registered AES-128 encryption round (SubBytes/ShiftRows/MixColumns/ARK).
// ROUND_LAST_EN adds a last_round input that bypasses MixColumns.
module round
    import round_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
`ifdef ROUND_LAST_EN
    input  logic                  last_round,
`endif
    input  logic [3:0][3:0][7:0]  roundin,
    input  logic [3:0][3:0][7:0]  key,
    output logic [3:0][3:0][7:0]  roundout
);

    state_t sub;
    state_t shifted;
    state_t mixed;
    state_t roundout_d;
    state_t roundout_q;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            aes_sbox u_sbox (
                .din  (roundin[r][c]),
                .dout (sub[r][c])
            );
        end
    end

    // Row r takes its column c byte from column (c + r) mod 4.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[r][c] = sub[r][2'(r + c)];
            end
        end
    end

    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[0][c] = xtime(shifted[0][c]) ^ xtime(shifted[1][c])
                        ^ shifted[1][c] ^ shifted[2][c] ^ shifted[3][c];
            mixed[1][c] = shifted[0][c] ^ xtime(shifted[1][c])
                        ^ xtime(shifted[2][c]) ^ shifted[2][c] ^ shifted[3][c];
            mixed[2][c] = shifted[0][c] ^ shifted[1][c]
                        ^ xtime(shifted[2][c]) ^ xtime(shifted[3][c]) ^ shifted[3][c];
            mixed[3][c] = xtime(shifted[0][c]) ^ shifted[0][c]
                        ^ shifted[1][c] ^ shifted[2][c] ^ xtime(shifted[3][c]);
        end
    end

    always_comb begin
        roundout_d = mixed ^ key;
`ifdef ROUND_LAST_EN
        if (last_round) begin
            roundout_d = shifted ^ key;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            roundout_q <= '0;
        end else begin
            roundout_q <= roundout_d;
        end
    end

    assign roundout = roundout_q;

endmodule

// File: tb/tb_round.sv
// Randomized self-checking bench for round against a GF(2^8) arithmetic model.
module tb_round;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 last_round = 1'b0;
    logic [3:0][3:0][7:0] roundin = '0;
    logic [3:0][3:0][7:0] key = '0;
    logic [3:0][3:0][7:0] roundout;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sbox_m [256];

    always #5 clk = ~clk;

    round dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ROUND_LAST_EN
        .last_round (last_round),
`endif
        .roundin    (roundin),
        .key        (key),
        .roundout   (roundout)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // FIPS byte string (byte 0 in the MSBs) to [row][col] state.
    function automatic logic [127:0] from_fips(input logic [127:0] v);
        logic [3:0][3:0][7:0] s;
        for (int i = 0; i < 16; i++) s[i % 4][i / 4] = v[127 - 8 * i -: 8];
        return s;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] din,
                                           input logic [127:0] k,
                                           input logic last);
        logic [3:0][3:0][7:0] s = din;
        logic [3:0][3:0][7:0] kk = k;
        logic [3:0][3:0][7:0] t;
        logic [3:0][3:0][7:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = sbox_m[s[r][(c + r) % 4]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (last)
                    o[r][c] = t[r][c];
                else
                    o[r][c] = gmul(8'h02, t[r][c])
                            ^ gmul(8'h03, t[(r + 1) % 4][c])
                            ^ t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
                o[r][c] = o[r][c] ^ kk[r][c];
            end
        return o;
    endfunction

    localparam logic [127:0] V_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] V_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
`ifdef ROUND_LAST_EN
    localparam logic [127:0] L_IN  = 128'heb598b1b402ea1c3f23813421e84e7d2;
    localparam logic [127:0] L_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] L_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
`endif

    initial begin
        logic [7:0] inv [256];
        logic [127:0] exp_q;
        logic [127:0] exp_n;

        // Reference S-box: multiplicative inverse then affine transform.
        inv[0] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv[a] = 8'(b);
        for (int a = 0; a < 256; a++)
            sbox_m[a] = inv[a] ^ rotl(inv[a], 1) ^ rotl(inv[a], 2)
                      ^ rotl(inv[a], 3) ^ rotl(inv[a], 4) ^ 8'h63;

        roundin = {$urandom, $urandom, $urandom, $urandom};
        key     = {$urandom, $urandom, $urandom, $urandom};
        #2 rst = 1'b0;
        #1 chk("rst_async", roundout, '0);
        @(posedge clk); #1;
        chk("rst_hold", roundout, '0);

        rst = 1'b1;
        roundin = '0;
        key = '0;
        @(posedge clk); #1;
        chk("zero_vec", roundout, {16{8'h63}});

        roundin = from_fips(V_IN);
        key = from_fips(V_KEY);
        @(posedge clk); #1;
        chk("fips_r1", roundout, from_fips(V_OUT));
        roundin = '0;
        key = '0;
        @(posedge clk); #1;
        chk("b2b_zero", roundout, {16{8'h63}});

`ifdef ROUND_LAST_EN
        roundin = from_fips(L_IN);
        key = from_fips(L_KEY);
        last_round = 1'b1;
        @(posedge clk); #1;
        chk("last_vec", roundout, from_fips(L_OUT));
        last_round = 1'b0;
`endif

        roundin = from_fips(V_IN);
        key = from_fips(V_KEY);
        #3 rst = 1'b0;
        #1 chk("rst_mid", roundout, '0);
        #2 rst = 1'b1;
        #1 chk("rst_release", roundout, '0);
        @(posedge clk); #1;
        chk("post_rst", roundout, from_fips(V_OUT));
        exp_q = from_fips(V_OUT);

        for (int i = 0; i < 300; i++) begin
            roundin = {$urandom, $urandom, $urandom, $urandom};
            key     = {$urandom, $urandom, $urandom, $urandom};
`ifdef ROUND_LAST_EN
            last_round = 1'($urandom_range(0, 1));
`endif
            exp_n = model(roundin, key, last_round);
            if (i % 16 == 0) begin
                #3 chk("hold", roundout, exp_q);
            end
            @(posedge clk); #1;
            chk("rand", roundout, exp_n);
            exp_q = exp_n;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
